fb_writer: RTL and testbench

- Downstream stage of the triangle rasterizer. Consumes its three bit-serial lanes: pixel X (Q10.6), pixel Y (Q10.6) and colour (16 bit).
- Deserializes each 16-bit word, converts coordinates to integer pixels and bounds-checks them. Buffers in-triangle pixels in a small FIFO and issues framebuffer writes over a valid/ready write port.
- Signals completion of each triangle once all of its pixels are written.

---
 rtl/fb_writer_pkg.sv | 23 ++
 rtl/fb_writer_pixel_fifo.sv | 49 ++++
 rtl/fb_writer.sv | 132 +++++++++++++
 tb/tb_fb_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_writer_pkg.sv
// Shared constants and types for the framebuffer writer: word format,
// default framebuffer geometry, FIFO entry layout and deserializer states.
package fb_writer_pkg;

    localparam int W          = 16;
    localparam int FRAC       = 6;
    localparam int WIDTH_DEF  = 320;
    localparam int HEIGHT_DEF = 240;
    localparam int AW_DEF     = 17;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [W-1:0]      color;
    } pix_entry_t;

    typedef enum logic [1:0] {
        DS_IDLE  = 2'd0,
        DS_SHIFT = 2'd1,
        DS_PUSH  = 2'd2
    } des_state_e;

endpackage

// File: rtl/fb_writer_pixel_fifo.sv
// Synchronous pixel FIFO; the head entry comes straight from storage, so
// there is no combinational path from push to the read side.
module pixel_fifo
    import fb_writer_pkg::*;
#(
    parameter type entry_t = pix_entry_t,
    parameter int  DEPTH   = DEPTH_DEF
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PW = $clog2(DEPTH);

    // Extra pointer bit distinguishes full from empty when the indices match.
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    entry_t      mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: deserializes X/Y/colour lanes, bounds-checks the pixel,
// queues it and drives the valid/ready write port; reports triangle completion.
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PSTART,
    input  logic          VALID,
    input  logic          PX,
    input  logic          PY,
    input  logic          C,
    input  logic          DONE,
    output logic          WE,
    input  logic          WREADY,
    output logic [AW-1:0] WADDR,
    output logic [W-1:0]  WDATA,
    output logic          TRI_DONE,
    output logic          OVF,
    output logic          ERR
);

    localparam int                BW       = $clog2(W);
    localparam logic [BW-1:0]     LAST_BIT = BW'(W - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  color;
    } wr_entry_t;

    des_state_e    state_q;
    logic [BW-1:0] cnt_q;
    logic [W-1:0]  x_sr_q, y_sr_q, c_sr_q;
    logic          vflag_q, err_q;
    logic          pending_q, pending_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  xi, yi;
    logic          in_bounds, push, pop, full, empty, tri_fire;
    wr_entry_t     push_entry, head;

    // Deserializer: a PSTART in PUSH starts the next word, mid-word it restarts and flags ERR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= DS_IDLE;
            cnt_q   <= '0;
            x_sr_q  <= '0;
            y_sr_q  <= '0;
            c_sr_q  <= '0;
            vflag_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (PSTART || state_q == DS_SHIFT) begin
                x_sr_q <= {x_sr_q[W-2:0], PX};
                y_sr_q <= {y_sr_q[W-2:0], PY};
                c_sr_q <= {c_sr_q[W-2:0], C};
            end
            case (state_q)
                DS_SHIFT: begin
                    if (PSTART) begin
                        err_q   <= 1'b1;
                        cnt_q   <= BW'(1);
                        vflag_q <= VALID;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) state_q <= DS_PUSH;
                    end
                end
                default: begin
                    if (PSTART) begin
                        cnt_q   <= BW'(1);
                        vflag_q <= VALID;
                        state_q <= DS_SHIFT;
                    end else begin
                        state_q <= DS_IDLE;
                    end
                end
            endcase
        end
    end

    // Arithmetic shift floors negative coordinates; the sign test rejects them anyway.
    assign xi        = W'($signed(x_sr_q) >>> FRAC);
    assign yi        = W'($signed(y_sr_q) >>> FRAC);
    assign in_bounds = !x_sr_q[W-1] && (int'(xi) < WIDTH) &&
                       !y_sr_q[W-1] && (int'(yi) < HEIGHT);
    assign push_entry = '{addr: AW'(yi) * AW'(WIDTH) + AW'(xi), color: c_sr_q};
    assign push       = (state_q == DS_PUSH) && vflag_q && in_bounds;
    assign pop        = !empty && WREADY;

    pixel_fifo #(
        .entry_t (wr_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // A DONE that coincides with the completion pulse is absorbed, never re-armed.
    assign tri_fire  = pending_q && (state_q == DS_IDLE) && empty;
    assign pending_d = tri_fire ? 1'b0 : (pending_q | DONE);
    assign ovf_d     = ovf_q | (push && full && !pop);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign WE       = !empty;
    assign WADDR    = empty ? '0 : head.addr;
    assign WDATA    = empty ? '0 : head.color;
    assign TRI_DONE = tri_fire;
    assign OVF      = ovf_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: directed scenarios plus randomized words
// compared against a queue-based model of the expected framebuffer writes.
module tb_fb_writer;
    import fb_writer_pkg::*;

    localparam int AW     = 17;
    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int DEPTH  = 4;

    logic          CLK = 1'b0, RST = 1'b1;
    logic          PSTART = 1'b0, VALID = 1'b0, PX = 1'b0, PY = 1'b0, C = 1'b0;
    logic          DONE = 1'b0, WREADY = 1'b0;
    logic          WE, TRI_DONE, OVF, ERR;
    logic [AW-1:0] WADDR;
    logic [15:0]   WDATA;

    fb_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .PSTART(PSTART), .VALID(VALID), .PX(PX), .PY(PY), .C(C),
        .DONE(DONE), .WE(WE), .WREADY(WREADY), .WADDR(WADDR), .WDATA(WDATA),
        .TRI_DONE(TRI_DONE), .OVF(OVF), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } due_t;

    int            n_checks = 0, n_errors = 0;
    int            cyc = 0, n_writes = 0, tri_cnt = 0;
    bit            rand_rdy = 1'b0, exp_ovf = 1'b0;
    logic [AW-1:0] last_waddr = '0;
    logic [15:0]   last_wdata = '0;
    logic [AW-1:0] exp_addr_q[$];
    logic [15:0]   exp_data_q[$];
    due_t          due_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference decode from the coordinate rules with plain integer arithmetic.
    function automatic bit ref_decode(input logic [15:0] x, input logic [15:0] y,
                                      output logic [AW-1:0] addr);
        int xs, ys, xi, yi;
        xs = int'($signed(x));
        ys = int'($signed(y));
        addr = '0;
        if (xs < 0 || ys < 0) return 1'b0;
        xi = xs / (1 << FRAC);
        yi = ys / (1 << FRAC);
        if (xi >= WIDTH || yi >= HEIGHT) return 1'b0;
        addr = AW'(yi * WIDTH + xi);
        return 1'b1;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Model: outstanding writes in order; a push lands 16 edges after its PSTART edge.
    always @(negedge CLK) begin
        if (RST) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            due_q.delete();
            exp_ovf = 1'b0;
        end else begin
            check("we", WE, exp_addr_q.size() != 0);
            check("ovf", OVF, exp_ovf);
            if (WE && exp_addr_q.size() != 0) begin
                check("waddr", WADDR, exp_addr_q[0]);
                check("wdata", WDATA, exp_data_q[0]);
            end
            if (WE && WREADY) begin
                n_writes++;
                last_waddr = WADDR;
                last_wdata = WDATA;
                if (exp_addr_q.size() != 0) begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
            end
            while (due_q.size() != 0 && due_q[0].due <= cyc + 1) begin
                due_t d;
                d = due_q.pop_front();
                if (exp_addr_q.size() >= DEPTH) exp_ovf = 1'b1;
                else begin
                    exp_addr_q.push_back(d.addr);
                    exp_data_q.push_back(d.data);
                end
            end
            if (TRI_DONE) tri_cnt++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_rdy) WREADY = ($urandom_range(0, 9) < 7);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_bits(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c,
                              input logic v, input int nbits, input int done_bit, input bit sched);
        logic [AW-1:0] a;
        for (int i = 15; i > 15 - nbits; i--) begin
            PSTART = (i == 15);
            VALID  = (i == 15) ? v : 1'($urandom);
            PX     = x[i];
            PY     = y[i];
            C      = c[i];
            DONE   = (i == done_bit);
            if (i == 15 && sched && v && ref_decode(x, y, a))
                due_q.push_back('{cyc + 17, a, c});
            tick();
        end
        PSTART = 1'b0;
        VALID  = 1'b0;
        DONE   = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c,
                             input logic v, input int done_bit);
        drive_bits(x, y, c, v, 16, done_bit, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  w0, t0;
        bit  seen;
        logic [15:0] rx, ry;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_we", WE, 0);
        check("rst_tri_done", TRI_DONE, 0);
        check("rst_ovf", OVF, 0);
        check("rst_err", ERR, 0);
        check("rst_waddr", WADDR, 0);
        check("rst_wdata", WDATA, 0);
        RST    = 1'b0;
        WREADY = 1'b1;
        idle(3);

        // Single pixel, latency and address.
        send_word(16'h0280, 16'h0140, 16'hF800, 1'b1, -1);
        @(negedge CLK);
        check("t1_we_before", WE, 0);
        tick();
        @(negedge CLK);
        check("t1_we", WE, 1);
        check("t1_waddr", WADDR, 1610);
        check("t1_wdata", WDATA, 16'hF800);
        tick();
        @(negedge CLK);
        check("t1_we_single", WE, 0);
        idle(2);

        // Fractional floor, then out-of-range coordinates.
        w0 = n_writes;
        send_word(16'h02BF, 16'h0140, 16'h07E0, 1'b1, -1);
        idle(4);
        check("t2_floor_writes", n_writes, w0 + 1);
        check("t2_floor_addr", last_waddr, 1610);
        check("t2_floor_data", last_wdata, 16'h07E0);
        send_word(16'h5000, 16'h0140, 16'h1234, 1'b1, -1);
        send_word(16'hFFC0, 16'h0140, 16'h5678, 1'b1, -1);
        send_word(16'h0000, 16'h3C00, 16'h9ABC, 1'b1, -1);
        idle(20);
        check("t2_oob_writes", n_writes, w0 + 1);
        check("t2_oob_ovf", OVF, 0);

        // Invalid pixel, then an empty triangle completes one cycle after DONE.
        w0 = n_writes;
        t0 = tri_cnt;
        send_word(16'h0280, 16'h0140, 16'hFFFF, 1'b0, -1);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        @(negedge CLK);
        check("t3_tri_done", TRI_DONE, 1);
        tick();
        @(negedge CLK);
        check("t3_tri_done_pulse", TRI_DONE, 0);
        idle(5);
        check("t3_no_write", n_writes, w0);
        check("t3_tri_count", tri_cnt, t0 + 1);

        // DONE during the last word: write first, then exactly one completion.
        w0 = n_writes;
        t0 = tri_cnt;
        seen = 1'b0;
        send_word(16'h1F40, 16'h0A00, 16'hABCD, 1'b1, 8);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (TRI_DONE) begin
                seen = 1'b1;
                check("t5_written_first", n_writes, w0 + 1);
            end
        end
        check("t5_tri_seen", seen, 1);
        idle(20);
        check("t5_tri_once", tri_cnt, t0 + 1);
        check("t5_addr", last_waddr, 40 * WIDTH + 125);

        // Randomized words with a randomly stalling write port.
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = 16'($urandom);
                ry = 16'($urandom);
            end else begin
                rx = 16'($urandom_range(0, WIDTH * 64 - 1));
                ry = 16'($urandom_range(0, HEIGHT * 64 - 1));
            end
            send_word(rx, ry, 16'($urandom), ($urandom_range(0, 4) != 0), -1);
            idle($urandom_range(0, 3));
        end
        rand_rdy = 1'b0;
        WREADY   = 1'b1;
        idle(30);
        check("rand_drained", exp_addr_q.size() + due_q.size(), 0);
        check("rand_ovf", OVF, 0);

        // Stall with five back-to-back pixels: four held, one dropped.
        WREADY = 1'b0;
        w0 = n_writes;
        for (int n = 0; n < 5; n++)
            send_word(16'((10 * n + 3) * 64), 16'((2 * n + 1) * 64), 16'(16'h0100 + n), 1'b1, -1);
        idle(25);
        check("t4_stalled", n_writes, w0);
        check("t4_ovf", OVF, 1);
        WREADY = 1'b1;
        idle(10);
        check("t4_drain_count", n_writes, w0 + 4);
        check("t4_last_data", last_wdata, 16'h0103);

        // PSTART mid-word restarts and flags ERR.
        check("t6_err_before", ERR, 0);
        w0 = n_writes;
        drive_bits(16'h0000, 16'h0000, 16'h0000, 1'b1, 10, -1, 1'b0);
        send_word(16'h0640, 16'h0300, 16'hCAFE, 1'b1, -1);
        idle(5);
        check("t6_err", ERR, 1);
        check("t6_restart_writes", n_writes, w0 + 1);
        check("t6_restart_addr", last_waddr, 12 * WIDTH + 25);

        // Reset mid-word with two entries queued.
        WREADY = 1'b0;
        send_word(16'h0040, 16'h0040, 16'h1111, 1'b1, -1);
        send_word(16'h0080, 16'h0040, 16'h2222, 1'b1, -1);
        drive_bits(16'h00C0, 16'h0040, 16'h3333, 1'b1, 6, -1, 1'b0);
        check("t6_queued", WE, 1);
        RST = 1'b1;
        #1;
        check("t6_rst_we", WE, 0);
        check("t6_rst_err", ERR, 0);
        check("t6_rst_ovf", OVF, 0);
        check("t6_rst_waddr", WADDR, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST    = 1'b0;
        WREADY = 1'b1;
        w0 = n_writes;
        idle(30);
        check("t6_no_writes_after", n_writes, w0);
        check("t6_tri_quiet", TRI_DONE, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
